// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry circular buffer of {pc, inst} pairs
// between fetch and decode, with valid/ready handshake and branch flush.
module if_id_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inValid,
  input  logic [31:0]              pcIn,
  input  logic [31:0]              instIn,
  output logic                     inReady,
  input  logic                     flush,
  input  logic                     outReady,
  output logic                     outValid,
  output logic [31:0]              pcOut,
  output logic [31:0]              instOut,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = 64;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push;
  logic          pop;
  logic [DW-1:0] head;

  // Handshake status and accepted transfers; flush overrides both sides
  always_comb begin
    inReady  = (count != CW'(DEPTH));
    outValid = (count != CW'(0));
    push     = inValid & inReady & ~flush;
    pop      = outValid & outReady & ~flush;
  end

  // Head entry, forced to zero when empty so decode sees a bubble
  always_comb begin
    head    = mem[rd_ptr];
    pcOut   = outValid ? head[63:32] : 32'h0;
    instOut = outValid ? head[31:0]  : 32'h0;
  end

  // Data storage; not reset, only written on an accepted push
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {pcIn, instIn};
    end
  end

  // Pointers and occupancy; full/empty are told apart by count alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= AW'(0);
      wr_ptr <= AW'(0);
      count  <= CW'(0);
    end else if (flush) begin
      rd_ptr <= AW'(0);
      wr_ptr <= AW'(0);
      count  <= CW'(0);
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH = 4).
module tb_if_id_queue;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic [31:0] pcIn;
  logic [31:0] instIn;
  logic        inReady;
  logic        flush;
  logic        outReady;
  logic        outValid;
  logic [31:0] pcOut;
  logic [31:0] instOut;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  if_id_queue #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .inValid  (inValid),
    .pcIn     (pcIn),
    .instIn   (instIn),
    .inReady  (inReady),
    .flush    (flush),
    .outReady (outReady),
    .outValid (outValid),
    .pcOut    (pcOut),
    .instOut  (instOut),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  // Advance one rising edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc);
    inValid = v;
    pcIn    = pc;
    instIn  = inst_of(pc);
  endtask

  task automatic test_reset();
    outReady = 1'b0;
    set_in(1'b1, 32'h10);
    step();
    set_in(1'b1, 32'h20);
    step();
    set_in(1'b0, 32'h0);
    checks++;
    if (count !== 3'd2) begin
      errors++; $display("FAIL reset_pre_count: got %0d want 2", count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (outValid !== 1'b0) begin
      errors++; $display("FAIL reset_outValid: got %b want 0", outValid);
    end
    checks++;
    if (pcOut !== 32'h0 || instOut !== 32'h0) begin
      errors++; $display("FAIL reset_data: got pc=%h inst=%h want 0/0", pcOut, instOut);
    end
    checks++;
    if (inReady !== 1'b1) begin
      errors++; $display("FAIL reset_inReady: got %b want 1", inReady);
    end
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", count);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_fill();
    outReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'(4 * (i + 1)));
      step();
      checks++;
      if (count !== 3'(i + 1)) begin
        errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1);
      end
      checks++;
      if (pcOut !== 32'd4) begin
        errors++; $display("FAIL fill_head[%0d]: got %0d want 4", i, pcOut);
      end
    end
    checks++;
    if (inReady !== 1'b0) begin
      errors++; $display("FAIL fill_inReady: got %b want 0", inReady);
    end
    set_in(1'b1, 32'd20);
    step();
    set_in(1'b0, 32'h0);
    checks++;
    if (count !== 3'd4 || pcOut !== 32'd4) begin
      errors++; $display("FAIL fill_overflow: got count=%0d pc=%0d want 4/4", count, pcOut);
    end
  endtask

  task automatic test_drain();
    outReady = 1'b1;
    set_in(1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pcOut !== 32'(4 * (i + 1)) || instOut !== inst_of(32'(4 * (i + 1)))) begin
        errors++; $display("FAIL drain_head[%0d]: got pc=%0d inst=%h want pc=%0d", i, pcOut, instOut, 4 * (i + 1));
      end
      step();
      checks++;
      if (inReady !== 1'b1) begin
        errors++; $display("FAIL drain_inReady[%0d]: got %b want 1", i, inReady);
      end
    end
    checks++;
    if (outValid !== 1'b0 || pcOut !== 32'h0 || count !== 3'd0) begin
      errors++; $display("FAIL drain_empty: got v=%b pc=%0d cnt=%0d want 0/0/0", outValid, pcOut, count);
    end
    outReady = 1'b0;
  endtask

  task automatic test_stream();
    outReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 32'(4 * (i + 1)));
      step();
      checks++;
      if (count !== 3'd1 || pcOut !== 32'(4 * (i + 1))) begin
        errors++; $display("FAIL stream[%0d]: got cnt=%0d pc=%0d want 1/%0d", i, count, pcOut, 4 * (i + 1));
      end
    end
    set_in(1'b0, 32'h0);
    step();
    checks++;
    if (count !== 3'd0 || outValid !== 1'b0) begin
      errors++; $display("FAIL stream_end: got cnt=%0d v=%b want 0/0", count, outValid);
    end
    outReady = 1'b0;
  endtask

  task automatic test_flush();
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'(4 * (i + 1)));
      step();
    end
    checks++;
    if (count !== 3'd3) begin
      errors++; $display("FAIL flush_pre_count: got %0d want 3", count);
    end
    flush    = 1'b1;
    outReady = 1'b1;
    set_in(1'b1, 32'd100);
    step();
    flush    = 1'b0;
    outReady = 1'b0;
    checks++;
    if (count !== 3'd0 || outValid !== 1'b0 || pcOut !== 32'h0) begin
      errors++; $display("FAIL flush_empty: got cnt=%0d v=%b pc=%0d want 0/0/0", count, outValid, pcOut);
    end
    set_in(1'b1, 32'd200);
    step();
    set_in(1'b0, 32'h0);
    checks++;
    if (count !== 3'd1 || outValid !== 1'b1 || pcOut !== 32'd200) begin
      errors++; $display("FAIL flush_refetch: got cnt=%0d v=%b pc=%0d want 1/1/200", count, outValid, pcOut);
    end
    outReady = 1'b1;
    step();
    outReady = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL flush_drain: got %0d want 0", count);
    end
  endtask

  task automatic test_full_pop();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'd8;
    exp_pc[1] = 32'd12;
    exp_pc[2] = 32'd16;
    exp_pc[3] = 32'd50;
    outReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'(4 * (i + 1)));
      step();
    end
    outReady = 1'b1;
    set_in(1'b1, 32'd50);
    step();
    checks++;
    if (count !== 3'd3 || pcOut !== 32'd8) begin
      errors++; $display("FAIL full_pop: got cnt=%0d pc=%0d want 3/8", count, pcOut);
    end
    outReady = 1'b0;
    step();
    set_in(1'b0, 32'h0);
    checks++;
    if (count !== 3'd4 || inReady !== 1'b0) begin
      errors++; $display("FAIL full_retry: got cnt=%0d rdy=%b want 4/0", count, inReady);
    end
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pcOut !== exp_pc[i]) begin
        errors++; $display("FAIL full_order[%0d]: got %0d want %0d", i, pcOut, exp_pc[i]);
      end
      step();
    end
    outReady = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL full_drain: got %0d want 0", count);
    end
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    outReady = 1'b0;
    set_in(1'b0, 32'h0);
    #12 rst = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_flush();
    test_full_pop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
